// File: rtl/klp32_pkg.sv
// Shared KLP32 front-end types and constants.
package klp32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// KLP32 fetch front end: credit-limited sequential prefetch into an in-order queue,
// with redirect flush and discard of stale in-flight imem responses.
module fetch_prefetch_unit
  import klp32_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_in,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_fetch_valid,
  input  logic        i_fetch_ready,
  output logic [31:0] o_fetch_inst,
  output logic [31:0] o_fetch_pc,
  output logic [31:0] o_fetch_pc_inc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   q_count, pend_count, live, resp_dec;
  logic [CW:0]     credit_sum;
  logic            q_empty, q_full, pend_empty, pend_full;
  logic            req_acc, resp_drop, q_push, q_pop;
  logic [XLEN-1:0] pend_pc;
  fetch_entry_t    q_head, q_in;
  logic            unused_sigs;

  assign live       = outstanding_q - discard_q;
  assign credit_sum = {1'b0, q_count} + {1'b0, live};

  // Gated by the reset pin so no request is ever presented while reset is held.
  assign o_imem_req_valid = reset && !i_pc_sel
                          && (credit_sum < (CW+1)'(DEPTH))
                          && (outstanding_q < CW'(MAX_OUTSTANDING));
  assign o_imem_addr      = fetch_pc_q;

  assign req_acc   = o_imem_req_valid && i_imem_req_ready;
  assign resp_drop = i_imem_resp_valid && (i_pc_sel || (discard_q != '0));
  assign q_push    = i_imem_resp_valid && !resp_drop;
  assign q_pop     = o_fetch_valid && i_fetch_ready;
  assign resp_dec  = CW'(i_imem_resp_valid);

  assign q_in.pc   = pend_pc;
  assign q_in.inst = i_imem_resp_data;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (i_pc_sel) begin
      fetch_pc_d    = {i_alu_in[31:2], 2'b00};
      outstanding_d = outstanding_q - resp_dec;
      discard_d     = outstanding_q - resp_dec;
    end else begin
      if (req_acc) fetch_pc_d = fetch_pc_q + PC_STEP;
      outstanding_d = outstanding_q + CW'(req_acc) - resp_dec;
      if (i_imem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Pending PCs are flushed on redirect; discarded responses never pop it.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (i_pc_sel),
    .push_i  (req_acc),
    .data_i  (fetch_pc_q),
    .pop_i   (q_push),
    .data_o  (pend_pc),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (pend_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (i_pc_sel),
    .push_i  (q_push),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign o_fetch_valid  = !q_empty;
  assign o_fetch_inst   = q_empty ? INST_NOP : q_head.inst;
  assign o_fetch_pc     = q_empty ? '0 : q_head.pc;
  assign o_fetch_pc_inc = q_empty ? '0 : q_head.pc + PC_STEP;

  assign unused_sigs = &{1'b0, pend_full, pend_empty, pend_count, q_full, i_alu_in[1:0]};

  resp_needs_request: assert property (@(posedge clk) disable iff (!reset)
    i_imem_resp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order variable-latency imem model.
module tb_fetch_prefetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, i_pc_sel, i_imem_req_ready, i_imem_resp_valid, i_fetch_ready;
  logic [31:0] i_alu_in, i_imem_resp_data;
  logic        o_imem_req_valid, o_fetch_valid;
  logic [31:0] o_imem_addr, o_fetch_inst, o_fetch_pc, o_fetch_pc_inc;

  logic        rst_drv, sel_drv, frdy_drv, irdy_drv;
  logic [31:0] alu_drv;
  logic [31:0] addr_q[$];
  int          due_q[$];
  int          checks = 0, errors = 0, cyc = 0, lat = 1, acc_cnt = 0, pop_cnt = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_pc_sel          (i_pc_sel),
    .i_alu_in          (i_alu_in),
    .o_imem_req_valid  (o_imem_req_valid),
    .i_imem_req_ready  (i_imem_req_ready),
    .o_imem_addr       (o_imem_addr),
    .i_imem_resp_valid (i_imem_resp_valid),
    .i_imem_resp_data  (i_imem_resp_data),
    .o_fetch_valid     (o_fetch_valid),
    .i_fetch_ready     (i_fetch_ready),
    .o_fetch_inst      (o_fetch_inst),
    .o_fetch_pc        (o_fetch_pc),
    .o_fetch_pc_inc    (o_fetch_pc_inc)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Inputs change at the falling edge; outputs and handshakes are sampled 1 ns later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    reset            = rst_drv;
    i_pc_sel         = sel_drv;
    i_alu_in         = alu_drv;
    i_fetch_ready    = frdy_drv;
    i_imem_req_ready = irdy_drv;
    if (addr_q.size() > 0 && due_q[0] <= cyc) begin
      i_imem_resp_valid = 1'b1;
      i_imem_resp_data  = inst_of(addr_q[0]);
      addr_q.delete(0);
      due_q.delete(0);
    end else begin
      i_imem_resp_valid = 1'b0;
      i_imem_resp_data  = 32'h0;
    end
    #1;
    if (o_imem_req_valid && i_imem_req_ready) begin
      addr_q.push_back(o_imem_addr);
      due_q.push_back(cyc + lat);
      acc_cnt++;
    end
    if (o_fetch_valid && i_fetch_ready) pop_cnt++;
  endtask

  task automatic do_reset(input int latency, input logic frdy);
    rst_drv = 1'b0; sel_drv = 1'b0; alu_drv = 32'h0; frdy_drv = frdy; irdy_drv = 1'b1;
    lat = latency;
    addr_q.delete(); due_q.delete();
    repeat (3) cycle();
    acc_cnt = 0; pop_cnt = 0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    do_reset(1, 1'b1);
    checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", o_fetch_valid); end
    checks++; if (o_fetch_inst !== NOP) begin errors++; $display("FAIL rst_inst: got %h want %h", o_fetch_inst, NOP); end
    checks++; if (o_fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", o_fetch_pc); end
    checks++; if (o_fetch_pc_inc !== 32'h0) begin errors++; $display("FAIL rst_pc_inc: got %h want 0", o_fetch_pc_inc); end
    checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %0b want 0", o_imem_req_valid); end
    rst_drv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      e = 32'(4 * i);
      checks++;
      if (o_imem_req_valid !== 1'b1 || o_imem_addr !== e) begin
        errors++; $display("FAIL stream_req[%0d]: got v=%0b a=%h want v=1 a=%h", i, o_imem_req_valid, o_imem_addr, e);
      end
      if (i < 2) begin
        checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d]: got %0b want 0", i, o_fetch_valid); end
      end else begin
        e = 32'(4 * (i - 2));
        checks++;
        if (o_fetch_valid !== 1'b1 || o_fetch_pc !== e || o_fetch_pc_inc !== e + 32'd4 || o_fetch_inst !== inst_of(e)) begin
          errors++; $display("FAIL stream_head[%0d]: got v=%0b pc=%h inc=%h inst=%h want pc=%h", i, o_fetch_valid, o_fetch_pc, o_fetch_pc_inc, o_fetch_inst, e);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    int          npop, bad;
    frdy_drv = 1'b0;
    bad = 0;
    repeat (12) begin
      cycle();
      if (acc_cnt - pop_cnt > 4 || o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'd24) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %0b want 0", o_imem_req_valid); end
    checks++; if (acc_cnt != 10) begin errors++; $display("FAIL stall_requests: got %0d want 10", acc_cnt); end
    frdy_drv = 1'b1;
    e = 32'd24; npop = 0;
    repeat (10) begin
      cycle();
      if (o_fetch_valid && i_fetch_ready) begin
        checks++;
        if (o_fetch_pc !== e || o_fetch_inst !== inst_of(e)) begin
          errors++; $display("FAIL stall_resume_pop: got pc=%h inst=%h want pc=%h", o_fetch_pc, o_fetch_inst, e);
        end
        e += 32'd4; npop++;
      end
    end
    checks++; if (npop != 10) begin errors++; $display("FAIL stall_resume_count: got %0d want 10", npop); end
  endtask

  task automatic test_redirect();
    int k;
    do_reset(3, 1'b1);
    rst_drv = 1'b1;
    repeat (3) cycle();
    checks++; if (acc_cnt != 3) begin errors++; $display("FAIL redir_inflight: got %0d want 3", acc_cnt); end
    sel_drv = 1'b1; alu_drv = 32'h0000_0103;
    cycle();
    checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %0b want 0", o_imem_req_valid); end
    sel_drv = 1'b0;
    cycle();
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_target: got v=%0b a=%h want v=1 a=00000100", o_imem_req_valid, o_imem_addr);
    end
    k = 1;
    while (!o_fetch_valid && k < 20) begin cycle(); k++; end
    checks++; if (k != 5) begin errors++; $display("FAIL redir_latency: got %0d want 5", k); end
    checks++;
    if (o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'h100 || o_fetch_inst !== inst_of(32'h100)) begin
      errors++; $display("FAIL redir_first: got v=%0b pc=%h inst=%h want pc=00000100", o_fetch_valid, o_fetch_pc, o_fetch_inst);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset(1, 1'b1);
    rst_drv = 1'b1;
    repeat (4) cycle();
    sel_drv = 1'b1; alu_drv = 32'h0000_0200;
    cycle();
    checks++;
    if (o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'h8 || o_imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rpop_setup: got v=%0b pc=%h req=%0b want v=1 pc=00000008 req=0", o_fetch_valid, o_fetch_pc, o_imem_req_valid);
    end
    sel_drv = 1'b0;
    cycle();
    checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL rpop_flushed: got %0b want 0", o_fetch_valid); end
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h200) begin
      errors++; $display("FAIL rpop_target: got v=%0b a=%h want v=1 a=00000200", o_imem_req_valid, o_imem_addr);
    end
    cycle();
    checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL rpop_stale: got %0b want 0", o_fetch_valid); end
    cycle();
    checks++;
    if (o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'h200 || o_fetch_pc_inc !== 32'h204 || o_fetch_inst !== inst_of(32'h200)) begin
      errors++; $display("FAIL rpop_first: got v=%0b pc=%h inc=%h inst=%h want pc=00000200", o_fetch_valid, o_fetch_pc, o_fetch_pc_inc, o_fetch_inst);
    end
  endtask

  task automatic test_wrap();
    sel_drv = 1'b1; alu_drv = 32'hFFFF_FFFF;
    cycle();
    sel_drv = 1'b0;
    cycle();
    checks++; if (o_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got %h want fffffffc", o_imem_addr); end
    cycle();
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_req1: got %h want 00000000", o_imem_addr); end
    cycle();
    checks++;
    if (o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'hFFFF_FFFC || o_fetch_pc_inc !== 32'h0 || o_fetch_inst !== inst_of(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_head0: got v=%0b pc=%h inc=%h inst=%h want pc=fffffffc inc=0", o_fetch_valid, o_fetch_pc, o_fetch_pc_inc, o_fetch_inst);
    end
    cycle();
    checks++;
    if (o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'h0 || o_fetch_pc_inc !== 32'h4) begin
      errors++; $display("FAIL wrap_head1: got v=%0b pc=%h inc=%h want pc=0 inc=4", o_fetch_valid, o_fetch_pc, o_fetch_pc_inc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(3, 1'b0);
    rst_drv = 1'b1;
    repeat (6) cycle();
    checks++;
    if (o_fetch_valid !== 1'b1 || o_fetch_pc !== 32'h0 || acc_cnt != 4) begin
      errors++; $display("FAIL rmid_setup: got v=%0b pc=%h acc=%0d want v=1 pc=0 acc=4", o_fetch_valid, o_fetch_pc, acc_cnt);
    end
    rst_drv = 1'b0;
    reset   = 1'b0;
    #1;
    checks++;
    if (o_fetch_valid !== 1'b0 || o_fetch_inst !== NOP || o_fetch_pc !== 32'h0 || o_fetch_pc_inc !== 32'h0) begin
      errors++; $display("FAIL rmid_outputs: got v=%0b inst=%h pc=%h inc=%h want 0/%h/0/0", o_fetch_valid, o_fetch_inst, o_fetch_pc, o_fetch_pc_inc, NOP);
    end
    checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req_valid: got %0b want 0", o_imem_req_valid); end
    addr_q.delete(); due_q.delete();
    frdy_drv = 1'b1;
    repeat (2) cycle();
    rst_drv = 1'b1;
    cycle();
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h0) begin
      errors++; $display("FAIL rmid_restart: got v=%0b a=%h want v=1 a=00000000", o_imem_req_valid, o_imem_addr);
    end
  endtask

  initial begin
    reset = 1'b0; i_pc_sel = 1'b0; i_alu_in = 32'h0; i_imem_req_ready = 1'b1;
    i_imem_resp_valid = 1'b0; i_imem_resp_data = 32'h0; i_fetch_ready = 1'b1;
    rst_drv = 1'b0; sel_drv = 1'b0; alu_drv = 32'h0; frdy_drv = 1'b1; irdy_drv = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
